// File: rtl/register_file.sv
// Multi-entry register file: one synchronous write port, two combinational read ports,
// with optional hardwired-zero entry 0 and optional same-cycle write-to-read forwarding.
module register_file #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter bit ZERO_REG = 1'b0,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [WIDTH-1:0]  rd_a,
  output logic [WIDTH-1:0]  rd_b
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                        wr_ok;

  // A write to entry 0 is dropped when it is hardwired to zero; reset beats any write.
  assign wr_ok = we && !reset && !(ZERO_REG && (wa == '0));

  always_comb begin
    mem_d = mem_q;
    if (reset) mem_d = '0;
    else if (wr_ok) mem_d[wa] = wd;
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  // Forwarding uses wr_ok, so it is off during reset and for a hardwired entry 0.
  always_comb begin
    rd_a = mem_q[ra];
    rd_b = mem_q[rb];
    if (BYPASS && wr_ok && (wa == ra)) rd_a = wd;
    if (BYPASS && wr_ok && (wa == rb)) rd_b = wd;
    if (ZERO_REG && (ra == '0)) rd_a = '0;
    if (ZERO_REG && (rb == '0)) rd_b = '0;
  end

endmodule
